// File: rtl/ext_dispatch_if.sv
// CPU extension port and shared arithmetic-unit bus seen by the dispatcher.
// slave: the dispatcher's view. master: the CPU and units' view.
interface ext_dispatch_if;
  logic        extStart;
  logic [31:0] extA;
  logic [31:0] extB;
  logic [2:0]  extFunc3;
  logic [31:0] extR;
  logic        extDone;
  logic        busy;
  logic        err;
  logic [31:0] uA;
  logic [31:0] uB;
  logic [2:0]  uFunc3;
  logic [1:0]  uStart;
  logic [1:0]  uDone;
  logic [31:0] uR0;
  logic [31:0] uR1;

  modport slave (
    input  extStart, extA, extB, extFunc3, uDone, uR0, uR1,
    output extR, extDone, busy, err, uA, uB, uFunc3, uStart
  );

  modport master (
    output extStart, extA, extB, extFunc3, uDone, uR0, uR1,
    input  extR, extDone, busy, err, uA, uB, uFunc3, uStart
  );
endinterface

// File: rtl/ext_dispatch.sv
// Sequencer between the CPU extension port and two arithmetic units (0: mul, 1: div/rem),
// with a watchdog that forces completion with ERR_RESULT if the selected unit never answers.
module ext_dispatch #(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_RESULT = 32'hFFFF_FFFF
) (
  input logic          clk,
  input logic          rst,
  ext_dispatch_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
  logic [31:0] ext_r_q, ext_r_d;
  logic [31:0] ua_q, ua_d;
  logic [31:0] ub_q, ub_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  ustart_q, ustart_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        unit_done;
  logic [31:0] unit_r;

  // Only the selected unit is ever listened to.
  assign unit_done = bus.uDone[sel_q];
  assign unit_r    = sel_q ? bus.uR1 : bus.uR0;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    ext_r_d  = ext_r_q;
    ua_d     = ua_q;
    ub_d     = ub_q;
    func3_d  = func3_q;
    ustart_d = 2'b00;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.extStart) begin
          ua_d     = bus.extA;
          ub_d     = bus.extB;
          func3_d  = bus.extFunc3;
          sel_d    = bus.extFunc3[2];
          ustart_d = bus.extFunc3[2] ? 2'b10 : 2'b01;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d = 8'd0;
        if (unit_done) begin
          ext_r_d = unit_r;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        // A result arriving on the last allowed cycle beats the watchdog.
        if (unit_done) begin
          ext_r_d = unit_r;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          ext_r_d = ERR_RESULT;
          to_d    = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        to_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      cnt_q    <= 8'd0;
      to_q     <= 1'b0;
      ext_r_q  <= 32'd0;
      ua_q     <= 32'd0;
      ub_q     <= 32'd0;
      func3_q  <= 3'd0;
      ustart_q <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      ext_r_q  <= ext_r_d;
      ua_q     <= ua_d;
      ub_q     <= ub_d;
      func3_q  <= func3_d;
      ustart_q <= ustart_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.extR    = ext_r_q;
  assign bus.extDone = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.uA      = ua_q;
  assign bus.uB      = ub_q;
  assign bus.uFunc3  = func3_q;
  assign bus.uStart  = ustart_q;

endmodule

// File: tb/tb_ext_dispatch.sv
// Self-checking bench for ext_dispatch: directed scenarios plus randomized requests checked
// against a cycle-count model of when and with what each request must complete.
module tb_ext_dispatch;

  localparam int unsigned T   = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ext_dispatch_if bus ();

  ext_dispatch #(
    .TIMEOUT   (T),
    .ERR_RESULT(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // One request; the selected unit raises uDone k cycles after the ISSUE cycle (k=0: in ISSUE).
  // Model: completion cycle = min(k, T) + 1 relative to ISSUE; result r if k <= T, else ERR.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input int k, input logic [31:0] r,
                        input bit spur, input bit coll, input bit b2b);
    int          sel;
    int          exp_c;
    logic [31:0] exp_r;
    bit          exp_err;
    logic [1:0]  exp_us;
    logic [1:0]  want_us;
    logic [1:0]  ud;
    sel     = int'(f3[2]);
    exp_c   = ((k <= int'(T)) ? k : int'(T)) + 1;
    exp_r   = (k <= int'(T)) ? r : ERR;
    exp_err = (k > int'(T));
    exp_us  = (sel == 1) ? 2'b10 : 2'b01;
    bus.extStart = 1'b1;
    bus.extA     = a;
    bus.extB     = b;
    bus.extFunc3 = f3;
    bus.uDone    = 2'b00;
    for (int c = 0; c <= exp_c + 1; c++) begin
      @(negedge clk);
      want_us = (c == 0) ? exp_us : 2'b00;
      n_checks++;
      if (bus.uStart !== want_us) begin
        n_errors++;
        $display("FAIL uStart c=%0d got %b want %b", c, bus.uStart, want_us);
      end
      n_checks++;
      if (bus.busy !== (c <= exp_c)) begin
        n_errors++;
        $display("FAIL busy c=%0d got %b want %b", c, bus.busy, (c <= exp_c));
      end
      n_checks++;
      if (bus.extDone !== (c == exp_c)) begin
        n_errors++;
        $display("FAIL extDone c=%0d got %b want %b", c, bus.extDone, (c == exp_c));
      end
      n_checks++;
      if (bus.err !== ((c == exp_c) && exp_err)) begin
        n_errors++;
        $display("FAIL err c=%0d got %b want %b", c, bus.err, ((c == exp_c) && exp_err));
      end
      n_checks++;
      if (bus.uA !== a || bus.uB !== b || bus.uFunc3 !== f3) begin
        n_errors++;
        $display("FAIL operands c=%0d got %h/%h/%b want %h/%h/%b",
                 c, bus.uA, bus.uB, bus.uFunc3, a, b, f3);
      end
      if (c >= exp_c) begin
        n_checks++;
        if (bus.extR !== exp_r) begin
          n_errors++;
          $display("FAIL extR c=%0d got %h want %h", c, bus.extR, exp_r);
        end
      end
      // Inputs for cycle c.
      bus.extStart = 1'b0;
      bus.extA     = $urandom;
      bus.extB     = $urandom;
      bus.extFunc3 = 3'($urandom);
      if (coll && c == 2) begin
        bus.extStart = 1'b1;
        bus.extA     = 32'd1;
      end
      if (b2b && c == exp_c) bus.extStart = 1'b1;
      if (c == exp_c + 1) bus.extStart = 1'b0;
      ud = 2'b00;
      if (c == k) ud[sel] = 1'b1;
      if (spur && c == 0) ud[1-sel] = 1'b1;
      bus.uDone = ud;
      bus.uR0   = $urandom;
      bus.uR1   = $urandom;
      if (c == k) begin
        if (sel == 1) bus.uR1 = r;
        else bus.uR0 = r;
      end
    end
    bus.uDone = 2'b00;
  endtask

  task automatic test_reset();
    bus.extStart = 1'b0;
    bus.extA     = 32'd0;
    bus.extB     = 32'd0;
    bus.extFunc3 = 3'd0;
    bus.uDone    = 2'b00;
    bus.uR0      = 32'd0;
    bus.uR1      = 32'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.extR, bus.extDone, bus.busy, bus.err, bus.uA, bus.uB, bus.uFunc3, bus.uStart}
        !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h/%b/%b/%b/%h/%h/%b/%b want all zero", bus.extR,
               bus.extDone, bus.busy, bus.err, bus.uA, bus.uB, bus.uFunc3, bus.uStart);
    end
    rst = 1'b1;
    // uDone held high while idle must not produce a completion.
    bus.uDone = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.extDone !== 1'b0 || bus.busy !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_udone got done=%b busy=%b want 0/0", bus.extDone, bus.busy);
      end
    end
    bus.uDone = 2'b00;
  endtask

  task automatic test_single_multiply();
    run_op(32'd7, 32'd6, 3'b000, 3, 32'd42, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_divide_routing();
    run_op(32'd100, 32'd7, 3'b100, 1, 32'd14, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_wait();
    run_op(32'd2, 32'd3, 3'b001, 0, 32'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(32'd9, 32'd0, 3'b101, 1000, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(32'd11, 32'd3, 3'b110, 2, 32'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    run_op(32'h55, 32'hAA, 3'b100, int'(T), 32'h1234_5678, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_collision();
    run_op(32'hDEAD_BEE0, 32'd4, 3'b010, 5, 32'hCAFE, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(32'h10, 32'h20, 3'b011, 2, 32'h30, 1'b0, 1'b0, 1'b1);
    run_op(32'h40, 32'h50, 3'b111, 0, 32'h60, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    bus.extStart = 1'b1;
    bus.extA     = 32'h77;
    bus.extB     = 32'h88;
    bus.extFunc3 = 3'b100;
    bus.uDone    = 2'b00;
    @(negedge clk);
    bus.extStart = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.extR, bus.extDone, bus.busy, bus.err, bus.uA, bus.uB, bus.uFunc3, bus.uStart}
        !== '0) begin
      n_errors++;
      $display("FAIL async_reset got %h/%b/%b/%b/%h/%h/%b/%b want all zero", bus.extR,
               bus.extDone, bus.busy, bus.err, bus.uA, bus.uB, bus.uFunc3, bus.uStart);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.uDone = 2'b10;
    bus.uR1   = 32'd123;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.uDone = 2'b00;
      n_checks++;
      if (bus.extDone !== 1'b0 || bus.busy !== 1'b0 || bus.extR !== 32'd0) begin
        n_errors++;
        $display("FAIL late_done got done=%b busy=%b extR=%h want 0/0/0",
                 bus.extDone, bus.busy, bus.extR);
      end
    end
    run_op(32'd8, 32'd9, 3'b000, 1, 32'd72, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, 3'($urandom), int'($urandom_range(0, T + 2)), $urandom,
             1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_multiply();
    test_divide_routing();
    test_zero_wait();
    test_timeout();
    test_simultaneous();
    test_busy_collision();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_dispatch.md
Name: ext_dispatch

Overview:
- Sequencer and arbiter between the CPU extension port (extA/extB/extFunc3/extStart → extR/extDone) and two external arithmetic units.
- Unit 0 is the multiplier (extFunc3[2]=0). Unit 1 is the divider/remainder unit (extFunc3[2]=1).
- Latches operands, issues a one-cycle start to the selected unit, and waits for that unit's done.
- Returns the result to the CPU with a one-cycle done. A watchdog guarantees the CPU never hangs on a dead unit.

Parameters:
- TIMEOUT, 64, max cycles spent in WAIT before forced completion (valid range 2..255).
- ERR_RESULT, 32'hFFFF_FFFF, value returned on extR on timeout.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- extStart  in  1  CPU request strobe, sampled only in IDLE.
- extA  in  32  operand A from CPU.
- extB  in  32  operand B from CPU.
- extFunc3  in  3  operation select; bit 2 selects the unit.
- extR  out  32  result to CPU.
- extDone  out  1  one-cycle completion pulse to CPU.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse, coincident with extDone, on timeout.
- uA  out  32  latched operand A, shared by both units.
- uB  out  32  latched operand B, shared by both units.
- uFunc3  out  3  latched extFunc3, shared by both units.
- uStart  out  2  per-unit start pulse; bit i drives unit i.
- uDone  in  2  per-unit done; bit i from unit i.
- uR0  in  32  result of unit 0.
- uR1  in  32  result of unit 1.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 (extR, extDone, busy, err, uA, uB, uFunc3, uStart); sel=0; counter=0. Reset mid-operation aborts silently: no extDone, and any result arriving later is dropped.
- IDLE:
  - extStart=1 at a posedge → latch uA=extA, uB=extB, uFunc3=extFunc3, sel=extFunc3[2].
  - Go to ISSUE.
  - extR holds its previous value.
- ISSUE (1 cycle):
  - uStart[sel]=1; uStart[~sel]=0.
  - Counter cleared to 0.
  - If uDone[sel]=1 → capture and go to DONE; otherwise go to WAIT.
- WAIT:
  - uStart=0.
  - uDone[sel]=1 → extR ≤ (sel ? uR1 : uR0); go to DONE.
  - Else if counter == TIMEOUT-1 → extR ≤ ERR_RESULT, set timeout flag, go to DONE.
  - Else counter += 1.
  - uDone of the non-selected unit is ignored in every state.
- DONE (1 cycle):
  - extDone=1; err=1 only if the timeout flag is set.
  - Go to IDLE; clear the timeout flag.
- extDone, err and uStart are registered single-cycle pulses.
- extR is stable from the DONE cycle until the next capture.
- uA, uB and uFunc3 hold from the latch until the next accepted extStart.
- Latency:
  - Minimum is 2 cycles: the extStart edge, then extDone is high in the cycle after the ISSUE edge (unit done seen in ISSUE).
  - In general, latency = 2 + number of WAIT cycles.
- Back-to-back: extStart asserted during the DONE cycle is ignored. A new request is accepted only from IDLE, so the earliest re-accept is the edge after DONE.
- extStart in ISSUE, WAIT or DONE is ignored, with no side effects. busy=1 tells the CPU to hold.
- Simultaneous uDone[sel] and counter==TIMEOUT-1 in WAIT: the unit's result wins; no err.
- A level-held uDone from a previous operation must not complete a new one. uDone is sampled only in ISSUE and WAIT, after this unit's uStart.

Test Plan:
- Single multiply: extA=7, extB=6, extFunc3=0, extStart pulse; unit 0 model answers uR0=42 with uDone[0] 3 cycles after uStart[0] → uStart=2'b01 for exactly 1 cycle; extDone 1 cycle with extR=42, err=0; busy high from ISSUE through DONE.
- Divide routing: extA=100, extB=7, extFunc3=3'b100; unit 1 returns 14 with done 1 cycle after uStart → uStart=2'b10; extR=14. A spurious uDone[0] pulse injected mid-operation has no effect.
- Zero-wait unit: uDone[0] tied high combinationally with uR0=5 → extDone exactly 2 cycles after the accepting edge; extR=5.
- Timeout: TIMEOUT=8, unit 1 never responds → extDone and err both pulse after ISSUE + 8 WAIT cycles; extR=32'hFFFF_FFFF. A following normal request completes with err=0.
- Busy collision: second extStart (extA=1) issued during WAIT → ignored; uA stays at the first operand; exactly one extDone.
- Async reset: drive rst=0 between clock edges while in WAIT → all outputs 0 immediately; a unit done arriving after reset is released produces no extDone; the next request works normally.
